// File: rtl/uart_imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
// Word assembly helpers live here so the packer and any checker agree on lane order.
package uart_loader_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DONE  = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

    localparam int          BYTES_PER_WORD  = 4;
    localparam logic [31:0] DEF_END_WORD    = 32'hFFFF_FFFF;
    localparam int          DEF_TIMEOUT_CYC = 500000;

    // Little-endian lane insert: lane 0 is bits [7:0].
    function automatic logic [31:0] put_lane(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data);
        logic [31:0] res;
        res = word;
        res[{lane, 3'b000} +: 8] = data;
        return res;
    endfunction

endpackage

// File: rtl/uart_imem_loader_byte_packer.sv
// Byte-lane packer: collects four received bytes into one little-endian word.
// word_ready_o/word_o are combinational so the owner can register the write one clock after the last byte.
module byte_packer
    import uart_loader_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  byte_idx_o,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;

    // Merge the incoming byte into its lane and decide the next packer state.
    always_comb begin
        shift_d      = shift_q;
        idx_d        = idx_q;
        word_o       = put_lane(shift_q, idx_q, byte_i);
        word_ready_o = byte_valid_i && !clr_i && (idx_q == LAST_LANE);
        if (clr_i) begin
            shift_d = 32'd0;
            idx_d   = 2'd0;
        end else if (byte_valid_i) begin
            if (idx_q == LAST_LANE) begin
                shift_d = 32'd0;
                idx_d   = 2'd0;
            end else begin
                shift_d = word_o;
                idx_d   = idx_q + 2'd1;
            end
        end else begin
            shift_d = shift_q;
            idx_d   = idx_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_q <= 32'd0;
            idx_q   <= 2'd0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign byte_idx_o = idx_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: streams UART bytes into instruction memory and holds the core in reset
// until a terminator word is received.
module uart_imem_loader
    import uart_loader_pkg::*;
#(
    parameter int                ADDR_W      = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [31:0]       END_WORD    = DEF_END_WORD,
    parameter int                TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_break,
    input  logic              reload,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic [31:0]       imem_wr_data,
    output logic              core_rst,
    output logic              write_done,
    output logic              load_error,
    output logic [ADDR_W:0]   word_count
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  TO_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WC_ONE   = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;

    logic        load_s, partial_s, timeout_s, pk_clr_s, pk_valid_s, word_ready_s;
    logic [1:0]  byte_idx_s;
    logic [31:0] word_s;

    // A BREAK only matters mid-word; in DONE/ERROR the packer is idle except for reload.
    always_comb begin
        load_s     = (state_q == ST_LOAD);
        partial_s  = (byte_idx_s != 2'd0);
        timeout_s  = load_s && partial_s && !rx_valid && (cnt_q == TO_LAST);
        pk_valid_s = load_s && rx_valid && !rx_break;
        pk_clr_s   = (load_s && rx_break && partial_s) || timeout_s || (!load_s && reload);
    end

    byte_packer u_packer (
        .clk          (clk),
        .resetn       (resetn),
        .clr_i        (pk_clr_s),
        .byte_valid_i (pk_valid_s),
        .byte_i       (rx_data),
        .byte_idx_o   (byte_idx_s),
        .word_o       (word_s),
        .word_ready_o (word_ready_s)
    );

    // Inter-byte idle counter: runs only while a word is partially assembled.
    always_comb begin
        if (!load_s || rx_valid || rx_break || !partial_s || (cnt_q == TO_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TO_ONE;
        end
    end

    // Load FSM: word write / terminator / overflow handling and reload.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        core_rst_d = core_rst_q;
        done_d     = done_q;
        err_d      = err_q;
        wcnt_d     = wcnt_q;
        case (state_q)
            ST_LOAD: begin
                if (!word_ready_s) begin
                    state_d = ST_LOAD;
                end else if (word_s == END_WORD) begin
                    state_d    = ST_DONE;
                    core_rst_d = 1'b0;
                    done_d     = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = word_s;
                    wcnt_d    = wcnt_q + WC_ONE;
                    // The last address is still written; the next word would have nowhere to go.
                    if (addr_q == '1) begin
                        state_d    = ST_ERROR;
                        err_d      = 1'b1;
                        core_rst_d = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (reload) begin
                    state_d    = ST_LOAD;
                    addr_d     = BASE_ADDR;
                    wcnt_d     = '0;
                    core_rst_d = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d    = ST_ERROR;
                core_rst_d = 1'b1;
                done_d     = 1'b0;
                err_d      = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_LOAD;
            addr_q     <= BASE_ADDR;
            cnt_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 32'd0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wcnt_q     <= wcnt_d;
        end
    end

    assign imem_wr_en   = wr_en_q;
    assign imem_wr_addr = wr_addr_q;
    assign imem_wr_data = wr_data_q;
    assign core_rst     = core_rst_q;
    assign write_done   = done_q;
    assign load_error   = err_q;
    assign word_count   = wcnt_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: a 10-bit and a 2-bit address instance share one byte stream
// and are compared every cycle against a word-level reference model.
module tb_uart_imem_loader;

    localparam int TO = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn, rx_valid, rx_break, reload;
    logic [7:0] rx_data;

    logic        b_wr_en, b_core_rst, b_done, b_err;
    logic [9:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic [10:0] b_wcnt;
    logic        s_wr_en, s_core_rst, s_done, s_err;
    logic [1:0]  s_wr_addr;
    logic [31:0] s_wr_data;
    logic [2:0]  s_wcnt;

    uart_imem_loader #(.ADDR_W(10), .TIMEOUT_CYC(TO)) u_dut_big (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_break(rx_break), .reload(reload),
        .imem_wr_en(b_wr_en), .imem_wr_addr(b_wr_addr), .imem_wr_data(b_wr_data),
        .core_rst(b_core_rst), .write_done(b_done), .load_error(b_err), .word_count(b_wcnt)
    );

    uart_imem_loader #(.ADDR_W(2), .TIMEOUT_CYC(TO)) u_dut_small (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_break(rx_break), .reload(reload),
        .imem_wr_en(s_wr_en), .imem_wr_addr(s_wr_addr), .imem_wr_data(s_wr_data),
        .core_rst(s_core_rst), .write_done(s_done), .load_error(s_err), .word_count(s_wcnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model, index 0 = 10-bit instance, 1 = 2-bit instance.
    // mode: 0 loading, 1 done, 2 error. Partial word kept as byte count + accumulator.
    int          amax [2] = '{1023, 3};
    int          m_mode [2];
    int          m_nb [2];
    logic [31:0] m_acc [2];
    int          m_idle [2];
    int          m_next [2];
    int          m_cnt [2];
    logic        m_wr [2];
    int          m_waddr [2];
    logic [31:0] m_wdata [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_nb[i] = 0; m_acc[i] = 32'd0; m_idle[i] = 0;
            m_next[i] = 0; m_cnt[i] = 0; m_wr[i] = 1'b0; m_waddr[i] = 0; m_wdata[i] = 32'd0;
        end
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic b, input logic r);
        logic [31:0] word;
        for (int i = 0; i < 2; i++) begin
            m_wr[i] = 1'b0;
            if (m_mode[i] == 0) begin
                if (b) begin
                    m_nb[i] = 0; m_acc[i] = 32'd0; m_idle[i] = 0;
                end else if (v) begin
                    m_acc[i] = m_acc[i] | (32'(d) << (8 * m_nb[i]));
                    m_nb[i]++;
                    m_idle[i] = 0;
                    if (m_nb[i] == 4) begin
                        word = m_acc[i];
                        m_nb[i] = 0; m_acc[i] = 32'd0;
                        if (word == 32'hFFFF_FFFF) begin
                            m_mode[i] = 1;
                        end else begin
                            m_wr[i] = 1'b1; m_waddr[i] = m_next[i]; m_wdata[i] = word;
                            m_cnt[i]++;
                            if (m_next[i] == amax[i]) m_mode[i] = 2;
                            else m_next[i]++;
                        end
                    end
                end else if (m_nb[i] > 0) begin
                    m_idle[i]++;
                    if (m_idle[i] == TO) begin
                        m_nb[i] = 0; m_acc[i] = 32'd0; m_idle[i] = 0;
                    end
                end
            end else if (r) begin
                m_mode[i] = 0; m_next[i] = 0; m_cnt[i] = 0;
                m_nb[i] = 0; m_acc[i] = 32'd0; m_idle[i] = 0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [63:0] o, e;
        o = {7'd0, b_wr_en, b_wr_addr, b_wr_data, b_core_rst, b_done, b_err, b_wcnt};
        e = {7'd0, m_wr[0], 10'(m_waddr[0]), m_wdata[0], m_mode[0] != 1, m_mode[0] == 1,
             m_mode[0] == 2, 11'(m_cnt[0])};
        chk_eq({tag, "_big"}, o, e);
        o = {7'd0, s_wr_en, 8'd0, s_wr_addr, s_wr_data, s_core_rst, s_done, s_err, 8'd0, s_wcnt};
        e = {7'd0, m_wr[1], 8'd0, 2'(m_waddr[1]), m_wdata[1], m_mode[1] != 1, m_mode[1] == 1,
             m_mode[1] == 2, 8'd0, 3'(m_cnt[1])};
        chk_eq({tag, "_small"}, o, e);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, sample 1 ns later.
    task automatic cyc(input logic v, input logic [7:0] d, input logic b, input logic r);
        rx_valid = v; rx_data = d; rx_break = b; reload = r;
        @(posedge clk);
        model_step(v, d, b, r);
        #1;
        rx_valid = 1'b0; rx_break = 1'b0; reload = 1'b0;
        compare_all("cyc");
    endtask

    task automatic send_byte(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        resetn = 1'b0; rx_valid = 1'b0; rx_break = 1'b0; reload = 1'b0; rx_data = 8'h00;
        @(posedge clk);
        #1;
        model_reset();
        compare_all("reset");
        resetn = 1'b1;
    endtask

    int sel;

    initial begin
        do_reset();
        chk_eq("rst_core_rst", 64'(b_core_rst), 64'd1);
        chk_eq("rst_wcnt", 64'(b_wcnt), 64'd0);

        // First word lands at address 0 one clock after its last byte.
        send_word(32'hFF01_0113);
        chk_eq("w1_en", 64'(b_wr_en), 64'd1);
        chk_eq("w1_addr", 64'(b_wr_addr), 64'd0);
        chk_eq("w1_data", 64'(b_wr_data), 64'hFF01_0113);
        chk_eq("w1_wcnt", 64'(b_wcnt), 64'd1);
        chk_eq("w1_core_rst", 64'(b_core_rst), 64'd1);
        idle(1);
        chk_eq("w1_pulse", 64'(b_wr_en), 64'd0);

        // Four words then two terminators.
        do_reset();
        send_word(32'h0000_0000);
        send_word(32'h0000_0000);
        send_word(32'hFF01_0113);
        send_word(32'h0081_2623);
        chk_eq("seq_addr3", 64'(b_wr_addr), 64'd3);
        chk_eq("small_err", 64'(s_err), 64'd1);
        send_word(32'hFFFF_FFFF);
        chk_eq("term_done", 64'(b_done), 64'd1);
        chk_eq("term_core_rst", 64'(b_core_rst), 64'd0);
        send_word(32'hFFFF_FFFF);
        chk_eq("term2_no_wr", 64'(b_wr_en), 64'd0);
        chk_eq("term2_wcnt", 64'(b_wcnt), 64'd4);

        // Reload from DONE (big) and ERROR (small).
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk_eq("reload_core_rst", 64'(b_core_rst), 64'd1);
        chk_eq("reload_done", 64'(b_done), 64'd0);
        chk_eq("reload_small_err", 64'(s_err), 64'd0);
        send_word(32'h0000_0013);
        chk_eq("reload_addr", 64'(b_wr_addr), 64'd0);
        chk_eq("reload_wr_en", 64'(b_wr_en), 64'd1);

        // Idle timeout drops a partial word.
        do_reset();
        send_byte(8'h13); send_byte(8'h01);
        idle(TO);
        send_word(32'h0081_2623);
        chk_eq("to_data", 64'(b_wr_data), 64'h0081_2623);
        chk_eq("to_addr", 64'(b_wr_addr), 64'd0);
        chk_eq("to_wcnt", 64'(b_wcnt), 64'd1);

        // One cycle short of the timeout keeps the partial word.
        do_reset();
        send_byte(8'hAA);
        idle(TO - 1);
        send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        chk_eq("to_edge_data", 64'(b_wr_data), 64'hDDCC_BBAA);

        // BREAK discards the partial word.
        do_reset();
        send_byte(8'h13);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        send_word(32'h0000_8067);
        chk_eq("brk_data", 64'(b_wr_data), 64'h0000_8067);

        // Small instance overflow.
        do_reset();
        for (int k = 0; k < 4; k++) send_word(32'h1122_3340 + 32'(k));
        chk_eq("ovf_err", 64'(s_err), 64'd1);
        chk_eq("ovf_addr", 64'(s_wr_addr), 64'd3);
        chk_eq("ovf_core_rst", 64'(s_core_rst), 64'd1);
        send_word(32'h1122_3344);
        chk_eq("ovf_5th_no_wr", 64'(s_wr_en), 64'd0);
        chk_eq("ovf_wcnt", 64'(s_wcnt), 64'd4);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk_eq("ovf_reload_err", 64'(s_err), 64'd0);
        send_word(32'h0000_0093);
        chk_eq("ovf_reload_addr", 64'(s_wr_addr), 64'd0);
        chk_eq("ovf_reload_en", 64'(s_wr_en), 64'd1);

        // Randomized traffic with BREAKs, reloads and near-timeout gaps.
        do_reset();
        for (int k = 0; k < 900; k++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 2) idle(int'($urandom_range(TO - 3, TO + 3)));
            else if (sel < 4) cyc(1'b0, 8'h00, 1'b1, 1'b0);
            else if (sel < 7) cyc(1'b0, 8'h00, 1'b0, 1'b1);
            else if (sel < 57) cyc(1'b1, ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom), 1'b0, 1'b0);
            else if (sel < 59) cyc(1'b1, 8'($urandom), 1'b1, 1'b0);
            else cyc(1'b0, 8'h00, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a word.
        do_reset();
        send_word(32'h0000_0013);
        send_word(32'h0000_0093);
        send_byte(8'h13);
        rx_valid = 1'b1; rx_data = 8'h01;
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        chk_eq("async_wcnt", 64'(b_wcnt), 64'd0);
        chk_eq("async_addr", 64'(b_wr_addr), 64'd0);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        send_word(32'h0000_0033);
        chk_eq("post_rst_addr", 64'(b_wr_addr), 64'd0);
        chk_eq("post_rst_data", 64'(b_wr_data), 64'h0000_0033);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
